phi0_step_gen: RTL and testbench



---
 rtl/phi0_step_gen.sv | 138 +++++++++++++
 tb/tb_phi0_step_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/phi0_step_gen.sv
// rtl/phi0_step_gen.sv - phi0 clock generator for the 6502C core: free-run, single-step, opcode-fetch breakpoint
// Define PHI0_BREAKPOINT_EN to build the breakpoint comparator and sticky bp_hit flag.
module phi0_step_gen #(
    parameter int HALF_PERIOD = 1024,
    parameter int CNT_W       = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_mode,
    input  logic        step_req,
    input  logic        sync_in,
    input  logic [15:0] addr_in,
    input  logic [15:0] bp_addr,
    input  logic        bp_arm,
    output logic        phi0_out,
    output logic        running,
    output logic        bp_hit,
    output logic [15:0] cycle_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] half_cnt;
    logic [CNT_W-1:0] half_cnt_next;
    logic [15:0]      cycle_count_q;
    logic [15:0]      cycle_count_next;
    logic             phi0_q;
    logic             step_req_q;
    logic             step_edge;
    logic             half_done;
    logic             cycle_done;
    logic             bp_hit_next;

    assign step_edge  = step_req & ~step_req_q;
    assign half_done  = (half_cnt == HALF_LAST);
    assign cycle_done = (state == LOW) & half_done;

`ifdef PHI0_BREAKPOINT_EN
    logic bp_hit_q;
    logic bp_match;

    assign bp_match = bp_arm & sync_in & (addr_in == bp_addr);

    // Disarming beats a coincident match; a step from IDLE acknowledges the hit.
    always_comb begin
        bp_hit_next = bp_hit_q;
        if (!bp_arm) begin
            bp_hit_next = 1'b0;
        end else if ((state == IDLE) && step_edge) begin
            bp_hit_next = 1'b0;
        end else if (cycle_done && bp_match) begin
            bp_hit_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bp_hit_q <= 1'b0;
        end else begin
            bp_hit_q <= bp_hit_next;
        end
    end

    assign bp_hit = bp_hit_q;
`else
    logic unused_bp_inputs;

    assign unused_bp_inputs = ^{sync_in, addr_in, bp_addr, bp_arm};
    assign bp_hit_next      = 1'b0;
    assign bp_hit           = 1'b0;
`endif

    always_comb begin
        state_next       = state;
        half_cnt_next    = half_cnt;
        cycle_count_next = cycle_count_q;
        case (state)
            IDLE: begin
                if ((run_mode & ~bp_hit) | step_edge) begin
                    state_next    = HIGH;
                    half_cnt_next = '0;
                end
            end
            HIGH: begin
                if (half_done) begin
                    state_next    = LOW;
                    half_cnt_next = '0;
                end else begin
                    half_cnt_next = half_cnt + CNT_ONE;
                end
            end
            LOW: begin
                if (half_done) begin
                    cycle_count_next = cycle_count_q + 16'd1;
                    half_cnt_next    = '0;
                    // Back-to-back HIGH keeps the free-run period at exactly 2*HALF_PERIOD.
                    state_next       = (run_mode & ~bp_hit_next) ? HIGH : IDLE;
                end else begin
                    half_cnt_next = half_cnt + CNT_ONE;
                end
            end
            default: begin
                state_next    = IDLE;
                half_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            half_cnt      <= '0;
            cycle_count_q <= 16'd0;
            phi0_q        <= 1'b0;
            step_req_q    <= 1'b0;
        end else begin
            state         <= state_next;
            half_cnt      <= half_cnt_next;
            cycle_count_q <= cycle_count_next;
            phi0_q        <= (state_next == HIGH);
            step_req_q    <= step_req;
        end
    end

    assign phi0_out    = phi0_q;
    assign running     = (state != IDLE);
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_phi0_step_gen.sv
// tb/tb_phi0_step_gen.sv - self-checking bench for phi0_step_gen (HALF_PERIOD=4 main unit, HALF_PERIOD=1 wrap unit)
module tb_phi0_step_gen;

    localparam int HP = 4;
`ifdef PHI0_BREAKPOINT_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run_mode = 1'b0;
    logic        step_req = 1'b0;
    logic        sync_in = 1'b0;
    logic [15:0] addr_in = 16'h0000;
    logic [15:0] bp_addr = 16'hE003;
    logic        bp_arm = 1'b0;
    logic        phi0_out;
    logic        running;
    logic        bp_hit;
    logic [15:0] cycle_count;

    logic        clk_w = 1'b0;
    logic        rst_w = 1'b1;
    logic        run_w = 1'b0;
    logic        w_phi0;
    logic        w_running;
    logic        w_bp_hit;
    logic [15:0] w_count;
    logic        wrap_done = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always #1 clk_w = ~clk_w;

    phi0_step_gen #(.HALF_PERIOD(HP), .CNT_W(24)) u_dut (
        .clk(clk), .rst(rst), .run_mode(run_mode), .step_req(step_req),
        .sync_in(sync_in), .addr_in(addr_in), .bp_addr(bp_addr), .bp_arm(bp_arm),
        .phi0_out(phi0_out), .running(running), .bp_hit(bp_hit), .cycle_count(cycle_count)
    );

    phi0_step_gen #(.HALF_PERIOD(1), .CNT_W(24)) u_wrap (
        .clk(clk_w), .rst(rst_w), .run_mode(run_w), .step_req(1'b0),
        .sync_in(1'b0), .addr_in(16'h0000), .bp_addr(16'hFFFF), .bp_arm(1'b0),
        .phi0_out(w_phi0), .running(w_running), .bp_hit(w_bp_hit), .cycle_count(w_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick_w;
        @(posedge clk_w);
        @(negedge clk_w);
    endtask

    // Reference model: a cycle is either absent or at position 0..2*HP-1; phi0 is high in the first half.
    bit          m_active = 1'b0;
    int          m_pos = 0;
    logic [15:0] m_cnt = 16'd0;
    bit          m_hit = 1'b0;
    bit          m_prev = 1'b0;

    always @(posedge clk) begin
        bit es;
        bit nh;
        es = step_req && !m_prev;
        m_prev = step_req;
        if (rst) begin
            m_active = 1'b0; m_pos = 0; m_cnt = 16'd0; m_hit = 1'b0; m_prev = 1'b0;
        end else if (!m_active) begin
            if ((run_mode && !m_hit) || es) begin
                m_active = 1'b1;
                m_pos = 0;
            end
            if (es || !bp_arm) m_hit = 1'b0;
        end else if (m_pos == 2 * HP - 1) begin
            m_cnt = m_cnt + 16'd1;
            nh = BP && bp_arm && (m_hit || (sync_in && addr_in == bp_addr));
            m_hit = nh;
            if (run_mode && !nh) m_pos = 0;
            else m_active = 1'b0;
        end else begin
            m_pos++;
            if (!bp_arm) m_hit = 1'b0;
        end
    end

    typedef struct {
        logic        step;
        logic        run;
        logic        exp_phi0;
        logic        exp_running;
        logic [15:0] exp_count;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'd0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'd0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'd0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd1};

        // reset and idle
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("idle_phi0", phi0_out, 1'b0);
            chk("idle_running", running, 1'b0);
            chk("idle_count", cycle_count, 16'd0);
        end

        // single step with a second edge ignored mid-cycle
        for (int i = 0; i < 10; i++) begin
            step_req = vecs[i].step;
            run_mode = vecs[i].run;
            tick();
            chk($sformatf("step_phi0[%0d]", i), phi0_out, vecs[i].exp_phi0);
            chk($sformatf("step_running[%0d]", i), running, vecs[i].exp_running);
            chk($sformatf("step_count[%0d]", i), cycle_count, vecs[i].exp_count);
        end

        // free-run, drop run_mode mid-HIGH of the sixth cycle
        run_mode = 1'b1;
        for (int j = 0; j < 48; j++) begin
            if (j == 42) run_mode = 1'b0;
            tick();
            chk("free_phi0", phi0_out, ((j % 8) < 4));
            chk("free_running", running, 1'b1);
        end
        tick();
        chk("free_stop_running", running, 1'b0);
        chk("free_stop_phi0", phi0_out, 1'b0);
        chk("free_stop_count", cycle_count, 16'd7);

        // breakpoint on the third cycle's opcode fetch
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bp_arm = 1'b1;
        bp_addr = 16'hE003;
        run_mode = 1'b1;
        for (int j = 0; j < 30; j++) begin
            sync_in = (j >= 17 && j <= 24);
            addr_in = (j >= 17 && j <= 24) ? 16'hE003 : 16'h1234;
            tick();
        end
        sync_in = 1'b0;
        addr_in = 16'h1234;
        chk("bp_count", cycle_count, 16'd3);
`ifdef PHI0_BREAKPOINT_EN
        chk("bp_hit_set", bp_hit, 1'b1);
        chk("bp_idle", running, 1'b0);
        run_mode = 1'b0;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("bp_step_clear", bp_hit, 1'b0);
        chk("bp_step_phi0", phi0_out, 1'b1);
        repeat (8) tick();
        chk("bp_step_done", running, 1'b0);
        chk("bp_step_count", cycle_count, 16'd4);
`else
        chk("bp_hit_tied", bp_hit, 1'b0);
        chk("bp_still_running", running, 1'b1);
        run_mode = 1'b0;
        repeat (3) tick();
        chk("nobp_done", running, 1'b0);
        chk("nobp_count", cycle_count, 16'd4);
`endif

        // reset in the middle of HIGH
        step_req = 1'b1;
        tick();
        tick();
        chk("rstmid_pre_phi0", phi0_out, 1'b1);
        rst = 1'b1;
        tick();
        chk("rstmid_phi0", phi0_out, 1'b0);
        chk("rstmid_running", running, 1'b0);
        chk("rstmid_count", cycle_count, 16'd0);
        chk("rstmid_bp_hit", bp_hit, 1'b0);
        rst = 1'b0;
        step_req = 1'b0;
        tick();

        // randomized run against the reference model
        bp_addr = 16'hE003;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) run_mode = ~run_mode;
            if ($urandom_range(0, 5) == 0) step_req = ~step_req;
            sync_in = $urandom_range(0, 1);
            addr_in = 16'hE000 | 16'($urandom_range(0, 7));
            bp_arm = ($urandom_range(0, 19) != 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
            chk("rand_phi0", phi0_out, (m_active && m_pos < HP));
            chk("rand_running", running, m_active);
            chk("rand_count", cycle_count, m_cnt);
            chk("rand_bp_hit", bp_hit, m_hit);
        end
        rst = 1'b0;

        for (int t = 0; t < 40000 && !wrap_done; t++) #100;
        chk("wrap_finished", wrap_done, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // 65536 cycles on the HALF_PERIOD=1 unit; cycle n completes at edge 2n after run starts
    initial begin
        repeat (3) tick_w();
        rst_w = 1'b0;
        run_w = 1'b1;
        repeat (131071) tick_w();
        chk("wrap_pre_count", w_count, 16'hFFFF);
        chk("wrap_pre_phi0", w_phi0, 1'b1);
        tick_w();
        run_w = 1'b0;
        tick_w();
        chk("wrap_count", w_count, 16'h0000);
        chk("wrap_idle", w_running, 1'b0);
        chk("wrap_bp_hit", w_bp_hit, 1'b0);
        wrap_done = 1'b1;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
